// File: rtl/reservation_station_if.sv
// Dispatch, wakeup and issue bundle for the reservation station.
// The master side is rename / writeback / functional unit; the slave side is the station.
interface reservation_station_if #(
    parameter int PREG_W = 6,
    parameter int OP_W   = 7
);
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_opcode;
    logic [PREG_W-1:0] disp_ps1;
    logic [PREG_W-1:0] disp_ps2;
    logic [PREG_W-1:0] disp_pd;
    logic [31:0]       disp_instr;
    logic              disp_rdy1;
    logic              disp_rdy2;

    logic              wb_valid;
    logic [PREG_W-1:0] wb_tag;

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_opcode;
    logic [PREG_W-1:0] issue_ps1;
    logic [PREG_W-1:0] issue_ps2;
    logic [PREG_W-1:0] issue_pd;
    logic [31:0]       issue_instr;

    modport master (
        output disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_pd, disp_instr,
               disp_rdy1, disp_rdy2, wb_valid, wb_tag, issue_ready,
        input  disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2,
               issue_pd, issue_instr
    );

    modport slave (
        input  disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_pd, disp_instr,
               disp_rdy1, disp_rdy2, wb_valid, wb_tag, issue_ready,
        output disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2,
               issue_pd, issue_instr
    );
endinterface

// File: rtl/reservation_station.sv
// Shared reservation station: age-ordered compacting queue, tag-broadcast wakeup, oldest-ready issue.
// Optional RS_FLUSH_EN adds a flush input that empties the station.
module reservation_station #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 6,
    parameter int OP_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef RS_FLUSH_EN
    input  logic                         flush,
`endif
    reservation_station_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd;
        logic [31:0]       instr;
        logic              rdy1;
        logic              rdy2;
    } entry_t;

    entry_t           ent     [DEPTH];
    entry_t           woken   [DEPTH];
    entry_t           ent_nxt [DEPTH];
    entry_t           new_ent;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] tail;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             issue_fire;
    logic             disp_fire;

    // Selection looks only at registered state, so wb_*/disp_* never reach issue_*.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && (CNT_W'(i) < count) && ent[i].rdy1 && ent[i].rdy2) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign bus.issue_valid  = sel_found;
    assign bus.issue_opcode = ent[sel_idx].opcode;
    assign bus.issue_ps1    = ent[sel_idx].ps1;
    assign bus.issue_ps2    = ent[sel_idx].ps2;
    assign bus.issue_pd     = ent[sel_idx].pd;
    assign bus.issue_instr  = ent[sel_idx].instr;

    // Credit comes from registered count only; a same-cycle issue does not reopen it.
    assign bus.disp_ready = (count < DEPTH_C);
    assign occupancy      = count;

    assign issue_fire = sel_found & bus.issue_ready;
    assign disp_fire  = bus.disp_valid & bus.disp_ready;

    // Incoming entry captures a wakeup broadcast on its own dispatch edge; p0 is always ready.
    always_comb begin
        new_ent        = '0;
        new_ent.opcode = bus.disp_opcode;
        new_ent.ps1    = bus.disp_ps1;
        new_ent.ps2    = bus.disp_ps2;
        new_ent.pd     = bus.disp_pd;
        new_ent.instr  = bus.disp_instr;
        new_ent.rdy1   = bus.disp_rdy1 | (bus.disp_ps1 == '0)
                       | (bus.wb_valid & (bus.wb_tag == bus.disp_ps1));
        new_ent.rdy2   = bus.disp_rdy2 | (bus.disp_ps2 == '0)
                       | (bus.wb_valid & (bus.wb_tag == bus.disp_ps2));
    end

    // Wakeup, then compaction over the issued slot, then append at the new tail.
    always_comb begin
        woken = ent;
        if (bus.wb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) < count) begin
                    if (ent[i].ps1 == bus.wb_tag) woken[i].rdy1 = 1'b1;
                    if (ent[i].ps2 == bus.wb_tag) woken[i].rdy2 = 1'b1;
                end
            end
        end

        ent_nxt = woken;
        if (issue_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) ent_nxt[i] = woken[i+1];
            end
        end

        tail = count - CNT_W'(issue_fire);
        if (disp_fire) ent_nxt[tail[IDX_W-1:0]] = new_ent;

        count_nxt = count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end

    // NOTE: only control state (count, ready bits) is reset; payload fields are qualified
    // by count, so leaving them unreset keeps the storage array free of reset fan-out.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].rdy1 <= 1'b0;
                ent[i].rdy2 <= 1'b0;
            end
`ifdef RS_FLUSH_EN
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].rdy1 <= 1'b0;
                ent[i].rdy2 <= 1'b0;
            end
`endif
        end else begin
            count <= count_nxt;
            ent   <= ent_nxt;
        end
    end

`ifndef SYNTHESIS
    count_bounded: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: directed dispatch/wakeup/issue scenarios.
// Build with +define+RS_FLUSH_EN to also exercise the flush path.
module tb_reservation_station;
    localparam int DEPTH  = 8;
    localparam int PREG_W = 6;
    localparam int OP_W   = 7;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd;
        logic [31:0]       instr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_in = 1'b0;
    logic [3:0] occupancy;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb_q[$];

    reservation_station_if #(.PREG_W(PREG_W), .OP_W(OP_W)) bus ();

    reservation_station #(.DEPTH(DEPTH), .PREG_W(PREG_W), .OP_W(OP_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RS_FLUSH_EN
        .flush     (flush_in),
`endif
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [PREG_W-1:0] pd);
        return 32'hC0DE_0000 | {26'd0, pd};
    endfunction

    function automatic logic [OP_W-1:0] mk_op(input logic [PREG_W-1:0] pd);
        return {1'b0, pd} ^ 7'h55;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid  = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.issue_ready = 1'b0;
        flush_in        = 1'b0;
    endtask

    task automatic drive_disp(input logic [PREG_W-1:0] ps1, input logic [PREG_W-1:0] ps2,
                              input logic [PREG_W-1:0] pd, input logic r1, input logic r2);
        bus.disp_valid  = 1'b1;
        bus.disp_opcode = mk_op(pd);
        bus.disp_ps1    = ps1;
        bus.disp_ps2    = ps2;
        bus.disp_pd     = pd;
        bus.disp_instr  = mk_instr(pd);
        bus.disp_rdy1   = r1;
        bus.disp_rdy2   = r2;
    endtask

    task automatic expect_issue(input logic [PREG_W-1:0] ps1, input logic [PREG_W-1:0] ps2,
                                input logic [PREG_W-1:0] pd);
        exp_t e;
        e.opcode = mk_op(pd);
        e.ps1    = ps1;
        e.ps2    = ps2;
        e.pd     = pd;
        e.instr  = mk_instr(pd);
        sb_q.push_back(e);
    endtask

    task automatic wake(input logic [PREG_W-1:0] tag);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = tag;
    endtask

    // Monitor: every accepted issue is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && !flush_in && bus.issue_valid && bus.issue_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue", {58'd0, bus.issue_pd}, 64'hFFFF);
            end else begin
                exp_t e;
                exp_t got;
                e = sb_q.pop_front();
                got.opcode = bus.issue_opcode;
                got.ps1    = bus.issue_ps1;
                got.ps2    = bus.issue_ps2;
                got.pd     = bus.issue_pd;
                got.instr  = bus.issue_instr;
                check("issued_entry", 64'(got), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.disp_opcode = '0;
        bus.disp_ps1    = '0;
        bus.disp_ps2    = '0;
        bus.disp_pd     = '0;
        bus.disp_instr  = '0;
        bus.disp_rdy1   = 1'b0;
        bus.disp_rdy2   = 1'b0;
        bus.wb_tag      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);

        // Single entry waiting on p6
        drive_disp(6'd5, 6'd6, 6'd10, 1'b1, 1'b0);
        tick(); idle();
        check("t1_not_ready", 64'(bus.issue_valid), 64'd0);
        check("t1_occ1", 64'(occupancy), 64'd1);
        wake(6'd6);
        tick(); idle();
        check("t1_woken", 64'(bus.issue_valid), 64'd1);
        check("t1_pd", 64'(bus.issue_pd), 64'd10);
        expect_issue(6'd5, 6'd6, 6'd10);
        bus.issue_ready = 1'b1;
        tick(); idle();
        check("t1_occ0", 64'(occupancy), 64'd0);

        // Younger ready entry bypasses older waiting one
        drive_disp(6'd7, 6'd3, 6'd11, 1'b0, 1'b1);
        tick();
        drive_disp(6'd1, 6'd2, 6'd12, 1'b1, 1'b1);
        tick(); idle();
        check("t2_occ2", 64'(occupancy), 64'd2);
        check("t2_sel_b", 64'(bus.issue_pd), 64'd12);
        expect_issue(6'd1, 6'd2, 6'd12);
        bus.issue_ready = 1'b1;
        tick(); idle();
        check("t2_occ1", 64'(occupancy), 64'd1);
        check("t2_a_waits", 64'(bus.issue_valid), 64'd0);
        wake(6'd7);
        tick(); idle();
        check("t2_a_ready", 64'(bus.issue_valid), 64'd1);
        expect_issue(6'd7, 6'd3, 6'd11);
        bus.issue_ready = 1'b1;
        tick(); idle();
        check("t2_occ0", 64'(occupancy), 64'd0);

        // Same-edge wakeup capture at dispatch
        drive_disp(6'd9, 6'd4, 6'd13, 1'b0, 1'b1);
        wake(6'd9);
        tick(); idle();
        check("t3_capture", 64'(bus.issue_valid), 64'd1);
        expect_issue(6'd9, 6'd4, 6'd13);
        bus.issue_ready = 1'b1;
        tick(); idle();

        // p0 sources always ready
        drive_disp(6'd0, 6'd0, 6'd14, 1'b0, 1'b0);
        tick(); idle();
        check("t4_p0_ready", 64'(bus.issue_valid), 64'd1);
        expect_issue(6'd0, 6'd0, 6'd14);
        bus.issue_ready = 1'b1;
        tick(); idle();
        check("t4_occ0", 64'(occupancy), 64'd0);

        // Fill, drop on full, issue from the middle
        for (int i = 0; i < DEPTH; i++) begin
            drive_disp(6'(20 + i), 6'd1, 6'(30 + i), 1'b0, 1'b1);
            tick();
        end
        idle();
        check("t5_full_occ", 64'(occupancy), 64'd8);
        check("t5_full_ready", 64'(bus.disp_ready), 64'd0);
        check("t5_none_ready", 64'(bus.issue_valid), 64'd0);
        drive_disp(6'd2, 6'd3, 6'd40, 1'b1, 1'b1);
        tick(); idle();
        check("t5_drop_occ", 64'(occupancy), 64'd8);
        check("t5_drop_valid", 64'(bus.issue_valid), 64'd0);
        wake(6'd23);
        tick(); idle();
        check("t5_mid_pd", 64'(bus.issue_pd), 64'd33);
        expect_issue(6'd23, 6'd1, 6'd33);
        bus.issue_ready = 1'b1;
        drive_disp(6'd2, 6'd3, 6'd41, 1'b1, 1'b1);
        tick(); idle();
        check("t5_no_bypass_occ", 64'(occupancy), 64'd7);
        check("t5_credit_back", 64'(bus.disp_ready), 64'd1);
        tick();
        check("t5_occ_hold", 64'(occupancy), 64'd7);
        expect_issue(6'd20, 6'd1, 6'd30);
        expect_issue(6'd21, 6'd1, 6'd31);
        expect_issue(6'd22, 6'd1, 6'd32);
        expect_issue(6'd24, 6'd1, 6'd34);
        expect_issue(6'd25, 6'd1, 6'd35);
        expect_issue(6'd26, 6'd1, 6'd36);
        expect_issue(6'd27, 6'd1, 6'd37);
        bus.issue_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 3) begin
                wake(6'(20 + i));
                tick();
            end
        end
        bus.wb_valid = 1'b0;
        tick(); idle();
        check("t5_drained", 64'(occupancy), 64'd0);

        // Dispatch and issue on the same edge
        drive_disp(6'd2, 6'd3, 6'd50, 1'b1, 1'b1);
        tick(); idle();
        expect_issue(6'd2, 6'd3, 6'd50);
        bus.issue_ready = 1'b1;
        drive_disp(6'd4, 6'd5, 6'd51, 1'b1, 1'b1);
        tick(); idle();
        check("t6_occ_same", 64'(occupancy), 64'd1);
        check("t6_next_pd", 64'(bus.issue_pd), 64'd51);
        expect_issue(6'd4, 6'd5, 6'd51);
        bus.issue_ready = 1'b1;
        tick(); idle();
        check("t6_occ0", 64'(occupancy), 64'd0);

`ifdef RS_FLUSH_EN
        // Flush discards everything, including same-cycle dispatch and issue
        for (int i = 0; i < 5; i++) begin
            drive_disp(6'(60 + i % 2), 6'd1, 6'(52 + i), 1'(i >= 3), 1'b1);
            tick();
        end
        idle();
        check("t7_occ5", 64'(occupancy), 64'd5);
        flush_in = 1'b1;
        bus.issue_ready = 1'b1;
        drive_disp(6'd2, 6'd3, 6'd45, 1'b1, 1'b1);
        tick(); idle();
        check("t7_flush_occ", 64'(occupancy), 64'd0);
        check("t7_flush_valid", 64'(bus.issue_valid), 64'd0);
        check("t7_flush_ready", 64'(bus.disp_ready), 64'd1);
        tick();
        check("t7_nothing_stored", 64'(bus.issue_valid), 64'd0);
`endif

        tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
